// File: rtl/mem_access_defs_pkg.sv
// Shared definitions for the load/store front-end: funct3 codes, FSM states,
// word-offset width and the request legality check.
package mem_access_defs;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned FUNCT3_W      = 3;
  // Byte-offset bits dropped to form the word-aligned RAM address
  localparam int unsigned WORD_OFFSET_W = 2;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Misaligned access or unsupported funct3 for the request class
  function automatic logic req_is_error(input logic                     write,
                                        input logic [FUNCT3_W-1:0]      funct3,
                                        input logic [WORD_OFFSET_W-1:0] offset);
    logic err;
    err = 1'b1;
    if (write) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = offset[0];
        F3_SW:   err = (offset != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = offset[0];
        F3_LW:         err = (offset != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Lane steering between a 32-bit RAM word and RISC-V sub-word accesses:
// extracts/extends load data and merges store data into the read word.
module byte_lane_align
  import mem_access_defs::*;
(
  input  logic [DATA_W-1:0]        word,
  input  logic [WORD_OFFSET_W-1:0] addr,
  input  logic [FUNCT3_W-1:0]      funct3,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        load_data_c,
  output logic [DATA_W-1:0]        store_word_c
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte and halfword lanes
  always_comb begin
    lane_byte = word[7:0];
    case (addr)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = addr[1] ? word[31:16] : word[15:0];
  end

  // Sign/zero extension of the selected lane
  always_comb begin
    load_data_c = '0;
    case (funct3)
      F3_LB:   load_data_c = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data_c = {{16{lane_half[15]}}, lane_half};
      F3_LW:   load_data_c = word;
      F3_LBU:  load_data_c = {24'h000000, lane_byte};
      F3_LHU:  load_data_c = {16'h0000, lane_half};
      default: load_data_c = '0;
    endcase
  end

  // Replace the addressed lanes of the read word with store data
  always_comb begin
    store_word_c = word;
    case (funct3)
      F3_SB: begin
        case (addr)
          2'd0:    store_word_c[7:0]   = wdata[7:0];
          2'd1:    store_word_c[15:8]  = wdata[7:0];
          2'd2:    store_word_c[23:16] = wdata[7:0];
          default: store_word_c[31:24] = wdata[7:0];
        endcase
      end
      F3_SH: begin
        if (addr[1]) store_word_c[31:16] = wdata[15:0];
        else         store_word_c[15:0]  = wdata[15:0];
      end
      F3_SW:   store_word_c = wdata;
      default: store_word_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end between the CPU memory stage and a word-addressed RAM.
// Sub-word stores are read-modify-write; illegal requests answer with an error
// without touching RAM. Optional MEM_ACCESS_STATS_EN adds per-class counters.
module mem_access_unit
  import mem_access_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [FUNCT3_W-1:0]   req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_input_data,
  output logic                  ram_should_write,
`ifdef MEM_ACCESS_STATS_EN
  output logic [31:0]           load_count,
  output logic [31:0]           store_count,
  output logic [31:0]           error_count,
`endif
  input  logic [DATA_WIDTH-1:0] ram_output_data
);

  state_t state_q, state_d;

  logic                  write_q;
  logic [FUNCT3_W-1:0]   funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] merged_q;

  logic                  accept;
  logic                  accept_err;
  logic [DATA_WIDTH-1:0] load_data_c;
  logic [DATA_WIDTH-1:0] store_word_c;

  assign accept     = req_valid && (state_q == ST_IDLE);
  assign accept_err = req_is_error(req_write, req_funct3, req_address[WORD_OFFSET_W-1:0]);

  byte_lane_align u_align (
    .word         (ram_output_data),
    .addr         (addr_q[WORD_OFFSET_W-1:0]),
    .funct3       (funct3_q),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (accept_err)                               state_d = ST_RESP;
          else if (req_write && (req_funct3 == F3_SW))  state_d = ST_WRITE;
          else                                          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, RAM read capture and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_address;
        wdata_q  <= req_wdata;
        err_q    <= accept_err;
        rdata_q  <= '0;
        merged_q <= req_wdata;
      end
      if (state_q == ST_READ) begin
        if (write_q) merged_q <= store_word_c;
        else         rdata_q  <= load_data_c;
      end
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_rdata       = rdata_q;
  assign resp_error       = err_q;
  assign ram_address      = {addr_q[ADDR_WIDTH-1:WORD_OFFSET_W], WORD_OFFSET_W'(0)};
  assign ram_input_data   = merged_q;
  // Reset gates the strobe directly so a write is dropped even mid-WRITE
  assign ram_should_write = (state_q == ST_WRITE) && !reset;

`ifdef MEM_ACCESS_STATS_EN
  // Per-class completion counters, advanced on the response cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
      error_count <= '0;
    end else if (state_q == ST_RESP) begin
      if (err_q)        error_count <= error_count + 32'd1;
      else if (write_q) store_count <= store_count + 32'd1;
      else              load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the CPU memory stage and the word-addressed `ram` block.
- Converts RISC-V byte, halfword and word loads/stores into aligned 32-bit RAM accesses.
  - Loads: lane-select and sign/zero extension.
  - Sub-word stores: read-modify-write.
  - Misaligned and illegal requests are reported as errors.
- Single outstanding request, valid/ready request side, one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM address.
- DATA_WIDTH, 32, word width; fixed at 32, other values unsupported.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, low bits used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned or illegal funct3; qualified by resp_valid.
- ram_address  output  32  {req_address[31:2], 2'b00} of the captured request.
- ram_input_data  output  32  merged write word.
- ram_should_write  output  1  RAM write enable (RAM writes on negedge).
- ram_output_data  input  32  combinational RAM read data.

Behaviour:
- Reset values: state IDLE; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_error=0, ram_should_write=0; all captured request registers 0.
- States: IDLE, READ, WRITE, RESP.
- Accept in cycle N (posedge ending N). The request is captured and the next state is selected:
  - error → RESP;
  - load → READ;
  - SB/SH → READ;
  - SW → WRITE.
- Error conditions:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010.
- Errors never touch RAM.
- READ (one cycle): ram_address driven; ram_output_data captured at posedge. Next state: load → RESP, store → WRITE.
- WRITE (one cycle):
  - ram_should_write = (state==WRITE) && !reset.
  - ram_input_data = captured word with the selected byte/halfword lanes replaced by req_wdata[7:0] or [15:0]; SW uses req_wdata unmodified.
  - Next state: RESP.
- RESP (one cycle): resp_valid=1, then IDLE. No response backpressure.
- Latencies (accept cycle N → resp_valid cycle):
  - error: N+1;
  - load: N+2;
  - SW: N+2;
  - SB/SH: N+3.
- Load extension: byte lane = addr[1:0], halfword lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- ram_should_write is 0 in every state except WRITE.
- req_ready=0 outside IDLE; inputs are ignored then and the captured request holds.
- Reset mid-operation: the FSM returns to IDLE at the next posedge, the in-flight response is dropped, and no RAM write occurs even if reset is asserted during WRITE.
- A back-to-back request may be accepted in the cycle after RESP.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined: adds 32-bit outputs load_count, store_count and error_count.
  - Each increments on the resp_valid cycle for its request class; errors count only in error_count.
  - Counters wrap modulo 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header mem_access_defs: funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), state encodings, and the aligned-address helper width constant.
- One combinational sub-module, byte_lane_align:
  - inputs: word, addr[1:0], funct3, wdata;
  - outputs: extended load data and merged store word;
  - instantiated once.

Test Plan:
1. RAM all zero; SW addr 0x4 data 0xDEADBEEF accepted at N → ram_should_write high only in N+1 with ram_address 0x4; resp_valid N+2; resp_error 0.
2. LB addr 0x7 → resp_rdata 0xFFFFFFDE at N+2; LBU addr 0x7 → 0x000000DE.
3. SB addr 0x5 data 0x00000012 → write in N+2 only, resp_valid N+3; subsequent LW addr 0x4 → 0xDEAD12EF.
4. LH addr 0x6 → 0xFFFFDEAD; LHU addr 0x6 → 0x0000DEAD; LH addr 0x5 → resp_valid N+1, resp_error 1, resp_rdata 0.
5. SW addr 0x2 and load funct3 011 → resp_error 1 at N+1; ram_should_write never asserted.
6. SH addr 0x4 with reset asserted during its WRITE cycle → no RAM write (LW 0x4 unchanged), no resp_valid, req_ready 1 the cycle after reset deasserts.
